// File: rtl/psram_qpi_responder_pkg.sv
// Shared PSRAM bus command codes and responder FSM state encoding.
package psram_qpi_responder_pkg;

  localparam logic [7:0] enableQPIModeCmd = 8'h35;
  localparam logic [7:0] SPIQuadWrite     = 8'h38;
  localparam logic [7:0] SPIQuadRead      = 8'hEB;
  localparam logic [7:0] exitQPIModeCmd   = 8'hF5;

  typedef enum logic [3:0] {
    sSpiIdle = 4'd0,
    sSpiCmd  = 4'd1,
    sIgnore  = 4'd2,
    sQpiIdle = 4'd3,
    sCmd     = 4'd4,
    sAddr    = 4'd5,
    sWrite   = 4'd6,
    sWait    = 4'd7,
    sRead    = 4'd8
  } PsramRespState;

endpackage

// File: rtl/psram_array.sv
// Single-port synchronous byte RAM; a read returns data one cycle after re_i.
module psram_array #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [7:0]           wdata_i,
  output logic [7:0]           rdata_o
);

  logic [7:0] mem_q [2**ADDR_BITS];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/psram_qpi_responder.sv
// QPI PSRAM device model: decodes SPI/QPI command sequences and serves a
// 4-bit nibble lane from an internal byte array.
module psram_qpi_responder
  import psram_qpi_responder_pkg::*;
#(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_CYCLES = 6
) (
  input  logic       i_clkRAM,
  input  logic       reset,
  input  logic       i_sclkEn,
  input  logic       i_psram_cs,
  input  logic [3:0] i_data,
  output logic [3:0] o_data,
  output logic       o_dataOe,
  output logic       o_qpiMode,
  output logic [3:0] o_state
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  PsramRespState state_q, state_d;
  logic        qpi_q, qpi_d;
  logic        oe_q, oe_d;
  logic [3:0]  dout_q, dout_d;
  logic [3:0]  nib_q, nib_d;
  logic [3:0]  wait_q, wait_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [3:0]  hi_q, hi_d;

  logic                 ram_we, ram_re;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [7:0]           ram_rdata;
  logic [7:0]           spi_byte, qpi_byte;

  assign spi_byte = {cmd_q[6:0], i_data[0]};
  assign qpi_byte = {cmd_q[3:0], i_data};

  always_comb begin
    state_d = state_q;
    qpi_d   = qpi_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    nib_d   = nib_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    hi_d    = hi_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;

    if (i_psram_cs) begin
      state_d = qpi_q ? sQpiIdle : sSpiIdle;
      oe_d    = 1'b0;
      nib_d   = 4'd0;
    end else if (i_sclkEn) begin
      case (state_q)
        sSpiIdle: begin
          cmd_d   = {7'd0, i_data[0]};
          nib_d   = 4'd1;
          state_d = sSpiCmd;
        end
        sSpiCmd: begin
          cmd_d = spi_byte;
          nib_d = nib_q + 4'd1;
          if (nib_q == 4'd7) begin
            if (spi_byte == enableQPIModeCmd) qpi_d = 1'b1;
            state_d = sIgnore;
          end
        end
        sQpiIdle: begin
          cmd_d   = qpi_byte;
          state_d = sCmd;
        end
        sCmd: begin
          cmd_d = qpi_byte;
          nib_d = 4'd0;
          case (qpi_byte)
            SPIQuadWrite, SPIQuadRead: state_d = sAddr;
            exitQPIModeCmd: begin
              qpi_d   = 1'b0;
              state_d = sIgnore;
            end
            default: state_d = sIgnore;
          endcase
        end
        sAddr: begin
          addr_d = {addr_q[19:0], i_data};
          nib_d  = nib_q + 4'd1;
          if (nib_q == 4'd5) begin
            nib_d  = 4'd0;
            wait_d = 4'd0;
            // Reads launch on the last address nibble so data is ready after the wait.
            if (cmd_q == SPIQuadRead) begin
              ram_re  = 1'b1;
              state_d = sWait;
            end else begin
              state_d = sWrite;
            end
          end
        end
        sWrite: begin
          if (!nib_q[0]) begin
            hi_d  = i_data;
            nib_d = 4'd1;
          end else begin
            ram_we = 1'b1;
            addr_d = addr_q + 24'd1;
            nib_d  = 4'd0;
          end
        end
        sWait: begin
          if (wait_q == WAIT_LAST) begin
            state_d = sRead;
            oe_d    = 1'b1;
            dout_d  = ram_rdata[7:4];
            nib_d   = 4'd0;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
        sRead: begin
          // The low-nibble cycle prefetches the next byte for the following high nibble.
          if (!nib_q[0]) begin
            dout_d = ram_rdata[3:0];
            addr_d = addr_q + 24'd1;
            ram_re = 1'b1;
            nib_d  = 4'd1;
          end else begin
            dout_d = ram_rdata[7:4];
            nib_d  = 4'd0;
          end
        end
        sIgnore: oe_d = 1'b0;
        default: state_d = sIgnore;
      endcase
    end
  end

  assign ram_addr = ram_we ? addr_q[ADDR_BITS-1:0] : addr_d[ADDR_BITS-1:0];

  always_ff @(posedge i_clkRAM) begin
    if (reset) begin
      state_q <= sSpiIdle;
      qpi_q   <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= 4'd0;
      nib_q   <= 4'd0;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      qpi_q   <= qpi_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      nib_q   <= nib_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge i_clkRAM) begin
    addr_q <= addr_d;
    cmd_q  <= cmd_d;
    hi_q   <= hi_d;
  end

  psram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk_i   (i_clkRAM),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i ({hi_q, i_data}),
    .rdata_o (ram_rdata)
  );

  assign o_data    = dout_q;
  assign o_dataOe  = oe_q;
  assign o_qpiMode = qpi_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Scoreboard bench for psram_qpi_responder: read nibbles are queued at issue
// and compared by a monitor whenever the DUT drives the lane.
module tb_psram_qpi_responder;
  import psram_qpi_responder_pkg::*;

  localparam int W = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       cs  = 1'b1;
  logic [3:0] din = 4'd0;
  logic [3:0] dout;
  logic       oe, qpi;
  logic [3:0] st;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];
  logic last_qual = 1'b0;

  psram_qpi_responder #(.ADDR_BITS(12), .WAIT_CYCLES(W)) dut (
    .i_clkRAM   (clk),
    .reset      (rst),
    .i_sclkEn   (en),
    .i_psram_cs (cs),
    .i_data     (din),
    .o_data     (dout),
    .o_dataOe   (oe),
    .o_qpiMode  (qpi),
    .o_state    (st)
  );

  always #5 clk = ~clk;

  always @(posedge clk) last_qual = !cs && en && !rst;

  // Monitor: each qualified edge with the lane driven yields one nibble.
  always @(negedge clk) begin
    if (oe && last_qual) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_nibble: got %h, no nibble expected", dout);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL read_nibble: got %h, expected %h", dout, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nib(input logic [3:0] n);
    cs = 1'b0; en = 1'b1; din = n;
    tick();
  endtask

  task automatic end_txn();
    cs = 1'b1; en = 1'b0; din = 4'd0;
    tick();
    tick();
  endtask

  // Upper lane bits set to 1 so only bit 0 may matter in SPI mode.
  task automatic spi_bits(input logic [7:0] b, input int first, input int last);
    for (int i = first; i >= last; i--) nib({3'b111, b[i]});
  endtask

  task automatic cmd_addr(input logic [7:0] c, input logic [23:0] a, input bit stall);
    nib(c[7:4]);
    nib(c[3:0]);
    for (int i = 5; i >= 0; i--) begin
      nib(a[i*4 +: 4]);
      if (stall && i == 3) begin
        en = 1'b0; din = 4'hF;
        for (int s = 0; s < 5; s++) tick();
        chk("stall_state", st, 32'(sAddr));
      end
    end
  endtask

  task automatic qpi_write(input logic [23:0] a, input int n, input logic [31:0] d);
    cmd_addr(SPIQuadWrite, a, 1'b0);
    for (int k = 0; k < n; k++) begin
      nib(d[31-8*k -: 4]);
      nib(d[27-8*k -: 4]);
    end
    end_txn();
  endtask

  task automatic qpi_read(input logic [23:0] a, input int n, input logic [31:0] d,
                          input bit stall, input bit keep);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(d[31-8*k -: 4]);
      exp_q.push_back(d[27-8*k -: 4]);
    end
    cmd_addr(SPIQuadRead, a, stall);
    for (int j = 1; j <= W + 2*n - 1; j++) begin
      nib(4'h0);
      if (j == W - 1) chk("oe_before_latency", oe, 0);
      if (j == W) chk("oe_rise", oe, 1);
    end
    if (!keep) end_txn();
  endtask

  initial begin
    bit oe_seen;
    repeat (3) tick();
    chk("reset_data", dout, 0);
    chk("reset_oe", oe, 0);
    chk("reset_qpi", qpi, 0);
    chk("reset_state", st, 32'(sSpiIdle));
    rst = 1'b0;
    tick();

    // Wrong SPI command lands in sIgnore and leaves SPI mode set.
    spi_bits(8'h36, 7, 0);
    chk("bad_cmd_qpi", qpi, 0);
    chk("bad_cmd_state", st, 32'(sIgnore));
    nib(4'h3); nib(4'h5);
    chk("ignore_holds", st, 32'(sIgnore));
    end_txn();
    chk("bad_cmd_idle", st, 32'(sSpiIdle));

    spi_bits(8'h35, 7, 1);
    chk("qpi_before_8th", qpi, 0);
    spi_bits(8'h35, 0, 0);
    chk("qpi_after_8th", qpi, 1);
    end_txn();
    chk("qpi_idle", st, 32'(sQpiIdle));

    qpi_write(24'h000123, 1, 32'hA5000000);
    qpi_read(24'h000123, 1, 32'hA5000000, 1'b0, 1'b0);

    // Burst wraps at the top of the 4 KiB array.
    qpi_write(24'h000FFF, 3, 32'h11223300);
    qpi_read(24'h000FFF, 3, 32'h11223300, 1'b0, 1'b0);
    qpi_read(24'h7F1000, 1, 32'h22000000, 1'b0, 1'b0);

    // Half a byte then CS high: nothing is written.
    cmd_addr(SPIQuadWrite, 24'h000123, 1'b0);
    nib(4'hF);
    end_txn();
    chk("partial_idle", st, 32'(sQpiIdle));
    qpi_read(24'h000123, 1, 32'hA5000000, 1'b0, 1'b0);

    qpi_read(24'h000FFF, 2, 32'h11220000, 1'b1, 1'b0);

    nib(exitQPIModeCmd[7:4]);
    nib(exitQPIModeCmd[3:0]);
    chk("exit_qpi", qpi, 0);
    chk("exit_state", st, 32'(sIgnore));
    end_txn();
    chk("exit_idle", st, 32'(sSpiIdle));
    spi_bits(8'h35, 7, 0);
    end_txn();
    chk("reenter_qpi", qpi, 1);

    // Reset in the middle of a read burst.
    qpi_read(24'h000123, 1, 32'hA5000000, 1'b0, 1'b1);
    chk("read_oe_active", oe, 1);
    rst = 1'b1;
    tick();
    chk("mid_reset_oe", oe, 0);
    chk("mid_reset_qpi", qpi, 0);
    chk("mid_reset_state", st, 32'(sSpiIdle));
    rst = 1'b0;
    end_txn();

    oe_seen = 1'b0;
    cmd_addr(SPIQuadRead, 24'h000123, 1'b0);
    for (int j = 0; j < W + 4; j++) begin
      nib(4'h0);
      if (oe) oe_seen = 1'b1;
    end
    chk("post_reset_no_read", oe_seen, 0);
    chk("post_reset_qpi", qpi, 0);
    end_txn();
    spi_bits(8'h35, 7, 0);
    end_txn();
    qpi_read(24'h000123, 1, 32'hA5000000, 1'b0, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
